// File: rtl/wsat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wsat_pkg
// Description : Shared types and constants for the WalkSAT flip selector.
// Revision    : 1.0 - initial release
// ============================================================================
package wsat_pkg;

  localparam int VAR_ADDR_W = 11;

  // x^16 + x^14 + x^13 + x^11 + 1, expressed as register bits 15/13/12/10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    RAND  = 2'd2,
    WRITE = 2'd3
  } fsel_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wsat_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : wsat_lfsr16
// Description : 16-bit Fibonacci LFSR, advances one step when step is high.
// Revision    : 1.0 - initial release
// ============================================================================
module wsat_lfsr16
  import wsat_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= SEED;
    end else if (step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/flip_selector.sv
`default_nettype none
// ============================================================================
// Module      : flip_selector
// Description : Picks the variable to flip from an unsatisfied 3-literal
//               clause (break-zero, noisy or greedy move) and issues a write.
//               Optional flip counter enabled by FLIP_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module flip_selector
  import wsat_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          BREAK_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VAR_ADDR_W-1:0] var_address1,
  input  logic [VAR_ADDR_W-1:0] var_address2,
  input  logic [VAR_ADDR_W-1:0] var_address3,
  input  logic                  v1_out,
  input  logic                  v2_out,
  input  logic                  v3_out,
  input  logic [BREAK_W-1:0]    break1,
  input  logic [BREAK_W-1:0]    break2,
  input  logic [BREAK_W-1:0]    break3,
  input  logic [7:0]            noise_p,
  output logic                  write,
  output logic [VAR_ADDR_W-1:0] flip_var_address,
  output logic                  flip_value,
  output logic                  skip
`ifdef FLIP_COUNTER_EN
  ,
  output logic [31:0]           flip_count
`endif
);

  fsel_state_t                     r_state;
  logic [2:0][VAR_ADDR_W-1:0]      r_addr;
  logic [2:0]                      r_v;
  logic [2:0][BREAK_W-1:0]         r_brk;
  logic [7:0]                      r_noise;

  logic [15:0]                     w_lfsr;
  logic                            w_step;
  logic                            w_unused_lfsr;
  logic [3:0]                      w_valid;
  logic [2:0]                      w_brk_zero;
  logic                            w_zero_hit;
  logic [1:0]                      w_zero_idx;
  logic [1:0]                      w_greedy_idx;
  logic [BREAK_W-1:0]              w_best;
  logic                            w_found;
  logic [1:0]                      w_cand;
  logic [1:0]                      w_n1;
  logic [1:0]                      w_n2;
  logic [1:0]                      w_noisy_idx;
  logic [1:0]                      w_rand_idx;
  logic [1:0]                      w_sel_idx;
  logic [VAR_ADDR_W-1:0]           w_sel_addr;
  logic                            w_sel_v;

  // The RAND decision uses the value present during RAND; the step lands at the end of it.
  assign w_step        = (r_state == RAND);
  assign w_unused_lfsr = ^w_lfsr[7:2];

  wsat_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (w_step),
    .q    (w_lfsr)
  );

  assign req_ready = (r_state == IDLE);
  assign w_valid   = {1'b0, |r_addr[2], |r_addr[1], |r_addr[0]};

  always_comb begin
    w_brk_zero = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_brk_zero[i] = w_valid[i] && (r_brk[i] == '0);
    end
  end

  assign w_zero_hit = |w_brk_zero;
  assign w_zero_idx = w_brk_zero[0] ? 2'd0 : (w_brk_zero[1] ? 2'd1 : 2'd2);

  // Strict less-than keeps the earliest slot on ties
  always_comb begin
    w_greedy_idx = 2'd0;
    w_best       = '1;
    w_found      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (w_valid[i] && (!w_found || (r_brk[i] < w_best))) begin
        w_found      = 1'b1;
        w_best       = r_brk[i];
        w_greedy_idx = 2'(i);
      end
    end
  end

  assign w_cand      = (w_lfsr[1:0] == 2'd3) ? 2'd0 : w_lfsr[1:0];
  assign w_n1        = (w_cand == 2'd2) ? 2'd0 : w_cand + 2'd1;
  assign w_n2        = (w_n1 == 2'd2) ? 2'd0 : w_n1 + 2'd1;
  assign w_noisy_idx = w_valid[w_cand] ? w_cand : (w_valid[w_n1] ? w_n1 : w_n2);
  assign w_rand_idx  = (w_lfsr[15:8] < r_noise) ? w_noisy_idx : w_greedy_idx;
  assign w_sel_idx   = (r_state == EVAL) ? w_zero_idx : w_rand_idx;

  always_comb begin
    w_sel_addr = r_addr[2];
    w_sel_v    = r_v[2];
    case (w_sel_idx)
      2'd0: begin
        w_sel_addr = r_addr[0];
        w_sel_v    = r_v[0];
      end
      2'd1: begin
        w_sel_addr = r_addr[1];
        w_sel_v    = r_v[1];
      end
      default: begin
        w_sel_addr = r_addr[2];
        w_sel_v    = r_v[2];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= IDLE;
      r_addr           <= '0;
      r_v              <= '0;
      r_brk            <= '0;
      r_noise          <= '0;
      write            <= 1'b0;
      skip             <= 1'b0;
      flip_var_address <= '0;
      flip_value       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          write <= 1'b0;
          skip  <= 1'b0;
          if (req_valid) begin
            r_addr  <= {var_address3, var_address2, var_address1};
            r_v     <= {v3_out, v2_out, v1_out};
            r_brk   <= {break3, break2, break1};
            r_noise <= noise_p;
            // Raised on entry so the pulse is visible during EVAL
            skip    <= (var_address1 == '0) && (var_address2 == '0) && (var_address3 == '0);
            r_state <= EVAL;
          end
        end
        EVAL: begin
          skip <= 1'b0;
          if (w_valid[2:0] == 3'b000) begin
            r_state <= IDLE;
          end else if (w_zero_hit) begin
            write            <= 1'b1;
            flip_var_address <= w_sel_addr;
            flip_value       <= ~w_sel_v;
            r_state          <= WRITE;
          end else begin
            r_state <= RAND;
          end
        end
        RAND: begin
          write            <= 1'b1;
          flip_var_address <= w_sel_addr;
          flip_value       <= ~w_sel_v;
          r_state          <= WRITE;
        end
        WRITE: begin
          write   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          write   <= 1'b0;
          skip    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef FLIP_COUNTER_EN
  logic [31:0] r_flip_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flip_count <= '0;
    end else if (write && (r_flip_count != 32'hFFFF_FFFF)) begin
      r_flip_count <= r_flip_count + 32'd1;
    end
  end

  assign flip_count = r_flip_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flip_selector.sv
`default_nettype none
// ============================================================================
// Module      : tb_flip_selector
// Description : Self-checking bench for flip_selector with a cycle-indexed
//               expectation queue and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flip_selector;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] var_address1 = '0, var_address2 = '0, var_address3 = '0;
  logic        v1_out = 1'b0, v2_out = 1'b0, v3_out = 1'b0;
  logic [7:0]  break1 = '0, break2 = '0, break3 = '0;
  logic [7:0]  noise_p = '0;
  logic        write;
  logic [10:0] flip_var_address;
  logic        flip_value;
  logic        skip;
`ifdef FLIP_COUNTER_EN
  logic [31:0] flip_count;
`endif

  flip_selector #(.LFSR_SEED(SEED), .BREAK_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .var_address1     (var_address1),
    .var_address2     (var_address2),
    .var_address3     (var_address3),
    .v1_out           (v1_out),
    .v2_out           (v2_out),
    .v3_out           (v3_out),
    .break1           (break1),
    .break2           (break2),
    .break3           (break3),
    .noise_p          (noise_p),
    .write            (write),
    .flip_var_address (flip_var_address),
    .flip_value       (flip_value),
    .skip             (skip)
`ifdef FLIP_COUNTER_EN
    ,
    .flip_count       (flip_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_skip;
    logic [10:0] addr;
    logic        val;
  } exp_t;

  exp_t        exq[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_lfsr = SEED;
  int          m_free = 0;
  int          m_flips = 0;
  int          last_acc = 0;
  int          last_w_cyc = -1;
  int          last_s_cyc = -1;
  int          n_w_seen = 0;
  logic [10:0] last_w_addr = '0;
  logic        last_w_val = 1'b0;
  int          cnt_addr [2048];

  bit          ew, es;
  logic [10:0] ea;
  logic        ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1: feedback from stages 16, 14, 13 and 11
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Called at a negedge while the block is idle; returns at a negedge once idle again.
  task automatic do_req(input logic [10:0] a1, a2, a3, input logic v1, v2, v3,
                        input logic [7:0] b1, b2, b3, input logic [7:0] np, input bit junk);
    logic [10:0] a [3];
    logic        v [3];
    int          b [3];
    bit          vld [3];
    int          nv, pick, lat, best, k, c;
    exp_t        e;
    a = '{a1, a2, a3};
    v = '{v1, v2, v3};
    b = '{int'(b1), int'(b2), int'(b3)};
    c = cyc;
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = (a[i] != 0);
      if (vld[i]) nv++;
    end
    if (nv == 0) begin
      e = '{cyc: c + 1, is_skip: 1'b1, addr: 11'd0, val: 1'b0};
      m_free = c + 2;
    end else begin
      pick = -1;
      for (int i = 0; i < 3; i++)
        if (pick < 0 && vld[i] && b[i] == 0) pick = i;
      if (pick >= 0) begin
        lat = 2;
      end else begin
        lat = 3;
        if (int'(m_lfsr[15:8]) < int'(np)) begin
          k = int'(m_lfsr[1:0]);
          if (k == 3) k = 0;
          while (!vld[k]) k = (k + 1) % 3;
          pick = k;
        end else begin
          best = 1 << 30;
          for (int i = 0; i < 3; i++)
            if (vld[i] && b[i] < best) begin
              best = b[i];
              pick = i;
            end
        end
        m_lfsr = ref_step(m_lfsr);
      end
      e = '{cyc: c + lat, is_skip: 1'b0, addr: a[pick], val: ~v[pick]};
      m_free = c + lat + 1;
    end
    exq.push_back(e);
    var_address1 = a1; var_address2 = a2; var_address3 = a3;
    v1_out = v1; v2_out = v2; v3_out = v3;
    break1 = b1; break2 = b2; break3 = b3;
    noise_p = np;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    var_address1 = 11'($urandom); var_address2 = 11'($urandom); var_address3 = 11'($urandom);
    v1_out = 1'($urandom); v2_out = 1'($urandom); v3_out = 1'($urandom);
    break1 = 8'($urandom); break2 = 8'($urandom); break3 = 8'($urandom);
    noise_p = 8'($urandom);
    if (junk && m_free > c + 2) begin
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
    end
    while (cyc < m_free) @(negedge clk);
    last_acc = c;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req_valid = 1'b0;
    exq.delete();
    m_lfsr = SEED;
    m_flips = 0;
    m_free = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2048; i++) cnt_addr[i] = 0;
  endtask

  // Per-cycle check against the expectation queue
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      ew = 1'b0; es = 1'b0; ea = '0; ev = 1'b0;
      while (exq.size() > 0 && exq[0].cyc < cyc) begin
        chk("event_lost", 32'(exq[0].cyc), 32'(cyc));
        void'(exq.pop_front());
      end
      if (exq.size() > 0 && exq[0].cyc == cyc) begin
        es = exq[0].is_skip;
        ew = !exq[0].is_skip;
        ea = exq[0].addr;
        ev = exq[0].val;
        void'(exq.pop_front());
      end
      chk("write", 32'(write), 32'(ew));
      chk("skip", 32'(skip), 32'(es));
      chk("req_ready", 32'(req_ready), 32'(cyc >= m_free));
      if (ew) begin
        chk("flip_var_address", 32'(flip_var_address), 32'(ea));
        chk("flip_value", 32'(flip_value), 32'(ev));
      end
`ifdef FLIP_COUNTER_EN
      chk("flip_count", flip_count, 32'(m_flips));
`endif
      if (ew) m_flips++;
      if (write) begin
        last_w_cyc  = cyc;
        last_w_addr = flip_var_address;
        last_w_val  = flip_value;
        n_w_seen++;
        cnt_addr[flip_var_address]++;
      end
      if (skip) last_s_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int c;
    clear_counts();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_skip", 32'(skip), 32'd0);
    chk("rst_addr", 32'(flip_var_address), 32'd0);
    chk("rst_value", 32'(flip_value), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_lfsr", 32'(dut.u_lfsr.q), 32'(SEED));
`ifdef FLIP_COUNTER_EN
    chk("rst_flip_count", flip_count, 32'd0);
`endif

    // Break-zero path
    do_req(11'd1, 11'd2, 11'd3, 1'b1, 1'b1, 1'b0, 8'd4, 8'd0, 8'd2, 8'h00, 1'b1);
    chk("bz_addr", 32'(last_w_addr), 32'd2);
    chk("bz_value", 32'(last_w_val), 32'd0);
    chk("bz_latency", 32'(last_w_cyc - last_acc), 32'd2);
    chk("bz_lfsr_hold", 32'(dut.u_lfsr.q), 32'(SEED));

    // First noisy move from the seed: lfsr[15:8]=AC < FF, lfsr[1:0]=1 -> slot 2
    do_req(11'd10, 11'd20, 11'd30, 1'b0, 1'b1, 1'b0, 8'd5, 8'd3, 8'd3, 8'hFF, 1'b0);
    chk("noisy_first_addr", 32'(last_w_addr), 32'd20);
    chk("noisy_first_value", 32'(last_w_val), 32'd0);
    chk("noisy_latency", 32'(last_w_cyc - last_acc), 32'd3);

    clear_counts();
    for (int i = 0; i < 1000; i++)
      do_req(11'd10, 11'd20, 11'd30, 1'($urandom), 1'($urandom), 1'($urandom),
             8'd5, 8'd3, 8'd3, 8'hFF, (i % 4) == 0);
    chk("noisy_slot1_hit", 32'(cnt_addr[10] > 0), 32'd1);
    chk("noisy_slot2_hit", 32'(cnt_addr[20] > 0), 32'd1);
    chk("noisy_slot3_hit", 32'(cnt_addr[30] > 0), 32'd1);

    // Greedy moves
    do_req(11'd10, 11'd20, 11'd30, 1'b1, 1'b0, 1'b1, 8'd5, 8'd3, 8'd3, 8'h00, 1'b1);
    chk("greedy_tie_addr", 32'(last_w_addr), 32'd20);
    chk("greedy_tie_value", 32'(last_w_val), 32'd1);
    chk("greedy_latency", 32'(last_w_cyc - last_acc), 32'd3);
    do_req(11'd10, 11'd20, 11'd30, 1'b0, 1'b0, 1'b0, 8'd7, 8'd7, 8'd2, 8'h00, 1'b0);
    chk("greedy_min3_addr", 32'(last_w_addr), 32'd30);
    do_req(11'd10, 11'd20, 11'd30, 1'b1, 1'b1, 1'b1, 8'd2, 8'd2, 8'd9, 8'h00, 1'b0);
    chk("greedy_tie_low_addr", 32'(last_w_addr), 32'd10);
    do_req(11'd0, 11'd20, 11'd30, 1'b0, 1'b0, 1'b0, 8'd1, 8'd6, 8'd6, 8'h00, 1'b0);
    chk("greedy_skip_invalid", 32'(last_w_addr), 32'd20);

    // Mixed vectors at a mid threshold, some slots unused
    for (int i = 0; i < 60; i++)
      do_req(($urandom % 3 == 0) ? 11'd0 : 11'($urandom_range(1, 2047)),
             ($urandom % 3 == 0) ? 11'd0 : 11'($urandom_range(1, 2047)),
             ($urandom % 3 == 0) ? 11'd0 : 11'($urandom_range(1, 2047)),
             1'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
             8'h80, (i % 2) == 0);

    // All slots unused
    snap = n_w_seen;
    do_req(11'd0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 8'd1, 8'hFF, 1'b0);
    chk("skip_latency", 32'(last_s_cyc - last_acc), 32'd1);
    chk("skip_no_write", 32'(n_w_seen), 32'(snap));

    // Address-0 slot never chosen
    do_req(11'd0, 11'd7, 11'd9, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'hFF, 1'b0);
    chk("a0_bz_addr", 32'(last_w_addr), 32'd7);
    chk("a0_bz_value", 32'(last_w_val), 32'd1);
    clear_counts();
    for (int i = 0; i < 200; i++)
      do_req(11'd0, 11'd7, 11'd9, 1'($urandom), 1'($urandom), 1'($urandom),
             8'd0, 8'd3, 8'd3, 8'hFF, 1'b0);
    for (int i = 0; i < 20; i++)
      do_req(11'd5, 11'd0, 11'd0, 1'($urandom), 1'b0, 1'b0, 8'd4, 8'd0, 8'd0, 8'hFF, 1'b0);
    chk("a0_never_written", 32'(cnt_addr[0]), 32'd0);
    chk("a0_slot2_hit", 32'(cnt_addr[7] > 0), 32'd1);
    chk("a0_slot3_hit", 32'(cnt_addr[9] > 0), 32'd1);
    chk("a0_single_slot", 32'(cnt_addr[5]), 32'd20);

    // Reset while in RAND aborts the request
`ifdef FLIP_COUNTER_EN
    chk("flip_count_total", flip_count, 32'(n_w_seen));
`endif
    c = cyc;
    var_address1 = 11'd10; var_address2 = 11'd20; var_address3 = 11'd30;
    break1 = 8'd5; break2 = 8'd3; break3 = 8'd3; noise_p = 8'h00;
    m_free = c + 4;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    snap = n_w_seen;
    apply_reset();
    repeat (5) @(negedge clk);
    chk("abort_no_write", 32'(n_w_seen), 32'(snap));
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_lfsr", 32'(dut.u_lfsr.q), 32'(SEED));
`ifdef FLIP_COUNTER_EN
    chk("abort_flip_count", flip_count, 32'd0);
`endif
    do_req(11'd10, 11'd20, 11'd30, 1'b1, 1'b1, 1'b0, 8'd5, 8'd3, 8'd3, 8'hFF, 1'b0);
    chk("reseed_noisy_addr", 32'(last_w_addr), 32'd20);
    chk("reseed_noisy_value", 32'(last_w_val), 32'd0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
